// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART MMIO blocks.
//   tx_state_t      serializer FSM states
//   UART_*          MMIO addresses decoded by the memory controller hub
//   TX_WORD_W       stored FIFO word width (32 in word mode, 8 otherwise)
//   TX_BYTES        bytes serialized per queued word
// Build option: define UART_TX_WORD_MODE_EN to send all four bytes of each
// stored word (LSB first); otherwise only push_data[7:0] is kept and sent.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, SEND, ACK, DRAIN} tx_state_t;

  localparam logic [31:0] UART_RX_DATA  = 32'hfffffff1;
  localparam logic [31:0] UART_RX_COUNT = 32'hfffffff2;
  localparam logic [31:0] UART_TX_DATA  = 32'hfffffff4;
  localparam logic [31:0] UART_TX_FREE  = 32'hfffffff8;

`ifdef UART_TX_WORD_MODE_EN
  localparam int TX_WORD_W = 32;
  localparam int TX_BYTES  = 4;
`else
  localparam int TX_WORD_W = 8;
  localparam int TX_BYTES  = 1;
`endif

endpackage

// File: rtl/uart_tx_queue_if.sv
// uart_tx_queue_if: core store port plus UartTx handshake of the TX queue.
//   push_en/push_data  qualified store to TX data MMIO (core -> queue)
//   push_stall         queue full, core holds the store
//   free_count         free entries, read back through TX free MMIO
//   tx_start/sdata     one-cycle start pulse and byte to UartTx
//   tx_busy            UartTx busy
//   idle               queue empty and serializer idle
// slave = the queue; master = core/hub plus UartTx side.
interface uart_tx_queue_if;
  logic        push_en;
  logic [31:0] push_data;
  logic        push_stall;
  logic [31:0] free_count;
  logic        tx_start;
  logic [7:0]  sdata;
  logic        tx_busy;
  logic        idle;

  modport master (output push_en, push_data, tx_busy,
                  input  push_stall, free_count, tx_start, sdata, idle);
  modport slave  (input  push_en, push_data, tx_busy,
                  output push_stall, free_count, tx_start, sdata, idle);
endinterface

// File: rtl/uart_tx_queue_fifo.sv
// sync_fifo: single-clock circular FIFO with show-ahead read.
//   clock, reset        clock, async active-low reset
//   push/push_data      write request (ignored while full)
//   pop/pop_data        read request (ignored while empty); pop_data = head
//   full, empty, count  status from registered occupancy
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    head, tail;
  logic             do_push, do_pop;

  // full comes from the registered count only, so a pop in a full cycle
  // does not open a slot for a push in that same cycle
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_push) tail <= tail + 1'b1;
      if (do_pop)  head <= head + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // storage needs no reset: entries are only read behind a valid count
  always_ff @(posedge clock) begin
    if (do_push) mem[tail] <= push_data;
  end

  assign pop_data = mem[head];
endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: buffers core stores to the TX data MMIO word and serializes
// them to UartTx through the tx_start/tx_busy handshake.
//   clock, reset  system clock, async active-low reset
//   bus (slave)   push_en/push_data/push_stall/free_count store side,
//                 tx_start/sdata/tx_busy UartTx side, idle status
// Build option: UART_TX_WORD_MODE_EN sends 4 bytes per word, LSB first;
// without it each word is a single byte (push_data[7:0]).
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input logic       clock,
  input logic       reset,
  uart_tx_queue_if.slave bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                 full, empty, pop;
  logic [CW-1:0]        count;
  logic [TX_WORD_W-1:0] head_word;

  tx_state_t  state, state_nx;
  logic       tx_start_q, tx_start_nx;
  logic [7:0] sdata_q, sdata_nx;

`ifdef UART_TX_WORD_MODE_EN
  logic [31:0] shreg, shreg_nx;
  logic [1:0]  bidx, bidx_nx;
`else
  logic [23:0] unused_push_hi;
  assign unused_push_hi = bus.push_data[31:8];
`endif

  sync_fifo #(.WIDTH(TX_WORD_W), .DEPTH(DEPTH)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (bus.push_en),
    .push_data (bus.push_data[TX_WORD_W-1:0]),
    .pop       (pop),
    .pop_data  (head_word),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      tx_start_q <= 1'b0;
      sdata_q    <= 8'h00;
`ifdef UART_TX_WORD_MODE_EN
      shreg      <= '0;
      bidx       <= '0;
`endif
    end else begin
      state      <= state_nx;
      tx_start_q <= tx_start_nx;
      sdata_q    <= sdata_nx;
`ifdef UART_TX_WORD_MODE_EN
      shreg      <= shreg_nx;
      bidx       <= bidx_nx;
`endif
    end
  end

  // tx_start/sdata are registered: they are set on the transition into SEND
  // so the pulse lines up with the SEND cycle.
  always_comb begin
    state_nx    = state;
    tx_start_nx = 1'b0;
    sdata_nx    = sdata_q;
    pop         = 1'b0;
`ifdef UART_TX_WORD_MODE_EN
    shreg_nx    = shreg;
    bidx_nx     = bidx;
`endif
    case (state)
      IDLE: if (!empty) begin
        pop         = 1'b1;
        sdata_nx    = head_word[7:0];
        tx_start_nx = 1'b1;
        state_nx    = SEND;
`ifdef UART_TX_WORD_MODE_EN
        shreg_nx    = head_word;
        bidx_nx     = '0;
`endif
      end
      SEND: state_nx = ACK;
      ACK:  if (bus.tx_busy) state_nx = DRAIN;
      DRAIN: if (!bus.tx_busy) begin
`ifdef UART_TX_WORD_MODE_EN
        if (bidx != 2'd3) begin
          // shift the next byte down into sdata
          shreg_nx    = shreg >> 8;
          sdata_nx    = shreg[15:8];
          bidx_nx     = bidx + 1'b1;
          tx_start_nx = 1'b1;
          state_nx    = SEND;
        end else begin
          state_nx    = IDLE;
        end
`else
        state_nx = IDLE;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.tx_start   = tx_start_q;
  assign bus.sdata      = sdata_q;
  assign bus.push_stall = bus.push_en & full;
  assign bus.free_count = 32'(DEPTH) - 32'(count);
  assign bus.idle       = empty & (state == IDLE);
endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue: scoreboard bench for uart_tx_queue (DEPTH=16) with a
// behavioural UartTx busy model. Stimulus pushes expected bytes into sb;
// the monitor pops and compares on every tx_start pulse.
module tb_uart_tx_queue;
  import uart_pkg::*;

  localparam int DEPTH = 16;
`ifdef UART_TX_WORD_MODE_EN
  localparam int NB = 4;
`else
  localparam int NB = 1;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  uart_tx_queue_if bus();
  uart_tx_queue #(.DEPTH(DEPTH)) dut (.clock(clock), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // UartTx model: busy rises busy_delay+1 cycles after the pulse, lasts busy_len
  logic busy_q = 1'b0;
  assign bus.tx_busy = busy_q;
  int  busy_len   = 4;
  int  busy_delay = 0;
  bit  hold_busy  = 0;
  int  dcnt = 0, bcnt = 0;

  always @(posedge clock) begin
    if (hold_busy) begin
      busy_q <= 1'b1; dcnt <= 0; bcnt <= 0;
    end else if (bus.tx_start) begin
      if (busy_delay == 0) begin busy_q <= 1'b1; bcnt <= busy_len; end
      else dcnt <= busy_delay;
    end else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) begin busy_q <= 1'b1; bcnt <= busy_len; end
    end else if (bcnt > 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) busy_q <= 1'b0;
    end else begin
      busy_q <= 1'b0;
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // scoreboard + monitor
  logic [7:0] sb[$];
  int pulse_cnt = 0;
  int pulse_cyc = 0;
  bit prev_start = 0, saw_hi = 0, saw_lo = 0, first = 1;

  always @(negedge clock) begin
    if (!reset) begin
      prev_start = 0; first = 1; saw_hi = 0; saw_lo = 0;
    end else if (bus.tx_start) begin
      pulse_cnt++;
      pulse_cyc = cyc;
      chk("start_back_to_back", 32'(prev_start), 0);
      if (!first) chk("busy_rise_fall_between_pulses", 32'(saw_lo), 1);
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse: got sdata %0h expected no pulse (t=%0t)", bus.sdata, $time);
      end else begin
        chk("sdata_order", 32'(bus.sdata), 32'(sb.pop_front()));
      end
      first = 0; saw_hi = 0; saw_lo = 0; prev_start = 1;
    end else begin
      prev_start = 0;
      if (bus.tx_busy) saw_hi = 1;
      else if (saw_hi) saw_lo = 1;
    end
  end

  task automatic expect_word(input logic [31:0] d);
    for (int b = 0; b < NB; b++) sb.push_back(d[8*b +: 8]);
  endtask

  task automatic push(input logic [31:0] d);
    int n = 0;
    @(negedge clock);
    bus.push_en = 1'b1; bus.push_data = d;
    #1;
    while (bus.push_stall && n < 2000) begin @(negedge clock); #1; n++; end
    if (bus.push_stall) begin
      checks++; errors++;
      $display("FAIL push_timeout: got stall after %0d cycles expected acceptance", n);
      bus.push_en = 1'b0;
      return;
    end
    @(posedge clock);
    expect_word(d);
    #1 bus.push_en = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int lim);
    int n = 0;
    do begin @(negedge clock); #1; n++; end
    while (!(bus.idle && sb.size() == 0) && n < lim);
    chk(nm, 32'(bus.idle), 1);
    chk({nm, "_sb_empty"}, 32'(sb.size()), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, n, tgt;
    bus.push_en = 1'b0; bus.push_data = '0;
    repeat (3) @(negedge clock);
    chk("rst_tx_start", 32'(bus.tx_start), 0);
    chk("rst_sdata", 32'(bus.sdata), 0);
    chk("rst_push_stall", 32'(bus.push_stall), 0);
    chk("rst_free_count", bus.free_count, 16);
    chk("rst_idle", 32'(bus.idle), 1);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    // single push, latency
    busy_len = 10;
    push(32'h0000_0041);
    @(negedge clock);
    chk("lat_free_c1", bus.free_count, 15);
    chk("lat_start_c1", 32'(bus.tx_start), 0);
    @(negedge clock);
    chk("lat_start_c2", 32'(bus.tx_start), 1);
    chk("lat_sdata_c2", 32'(bus.sdata), 32'h41);
    wait_idle("single_idle", 500);

    // fill to full with UartTx held busy
    hold_busy = 1;
    repeat (2) @(negedge clock);
    for (int i = 1; i <= 17; i++) begin
      logic [31:0] d;
      d = {8'(8'hC0 + i), 8'(8'h80 + i), 8'(8'h40 + i), 8'(i)};
      @(negedge clock);
      bus.push_en = 1'b1; bus.push_data = d;
      #1;
      chk("full_free_step", bus.free_count, (i == 1) ? 16 : (i == 2) ? 15 : 32'(18 - i));
      chk("full_no_stall", 32'(bus.push_stall), 0);
      @(posedge clock);
      expect_word(d);
      #1 bus.push_en = 1'b0;
    end
    @(negedge clock);
    bus.push_en = 1'b1; bus.push_data = 32'h0000_00EE;
    #1;
    chk("full_free_zero", bus.free_count, 0);
    chk("full_stall", 32'(bus.push_stall), 1);
    @(posedge clock);
    #1 bus.push_en = 1'b0;
    @(negedge clock);
    chk("full_not_accepted", bus.free_count, 0);
    hold_busy = 0;
    busy_len = 2;
    wait_idle("full_drain_idle", 3000);

    // pointer wrap
    busy_len = 1;
    for (int i = 0; i < 40; i++) push(32'(i));
    wait_idle("wrap_idle", 5000);

    // push in the same cycle as the FSM pop, count=5
    busy_len = 6;
    base = pulse_cnt;
    for (int i = 0; i < 6; i++) push(32'h50 + 32'(i));
    n = 0;
    while (pulse_cnt < base + NB && n < 1000) begin @(negedge clock); #1; n++; end
    chk("samecyc_first_word_sent", 32'(pulse_cnt >= base + NB), 1);
    tgt = pulse_cyc + busy_len + 2;
    while (cyc < tgt) @(negedge clock);
    bus.push_en = 1'b1; bus.push_data = 32'h0000_0077;
    #1;
    chk("samecyc_free_before", bus.free_count, 11);
    chk("samecyc_no_stall", 32'(bus.push_stall), 0);
    @(posedge clock);
    expect_word(32'h0000_0077);
    #1 bus.push_en = 1'b0;
    @(negedge clock);
    chk("samecyc_free_after", bus.free_count, 11);
    chk("samecyc_popped", 32'(bus.tx_start), 1);
    wait_idle("samecyc_idle", 2000);

    // delayed busy: ACK must wait
    busy_delay = 4; busy_len = 3;
    push(32'h0000_0031);
    push(32'h0000_0032);
    wait_idle("delay_idle", 1000);
    busy_delay = 0;

    // reset mid-DRAIN with 3 words queued
    busy_len = 20;
    base = pulse_cnt;
    for (int i = 0; i < 4; i++) push(32'h60 + 32'(i));
    n = 0;
    while (pulse_cnt <= base && n < 100) begin @(negedge clock); #1; n++; end
    repeat (3) @(negedge clock);
    chk("rstmid_free_before", bus.free_count, 13);
    reset = 1'b0;
    sb.delete();
    #1;
    chk("rstmid_tx_start", 32'(bus.tx_start), 0);
    chk("rstmid_sdata", 32'(bus.sdata), 0);
    chk("rstmid_free", bus.free_count, 16);
    chk("rstmid_idle", 32'(bus.idle), 1);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    base = pulse_cnt;
    repeat (60) @(negedge clock);
    #1;
    chk("rstmid_no_pulses", 32'(pulse_cnt - base), 0);
    chk("rstmid_idle_after", 32'(bus.idle), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Buffered UART transmit path behind the core's MMIO store port: the outbound counterpart of the receive ring buffer in the memory controller hub. Core stores to the TX data MMIO word are queued in a FIFO and serialized to UartTx via the tx_start/tx_busy handshake. The queue decouples core stores from UART speed, so software need not poll per byte. The hub decodes the TX data and TX free-count MMIO addresses, and this block serves them.

## Interface
Parameters:
- DEPTH, 16: FIFO entries (power of two, ≥2)

Ports (one clock; reset is asynchronous and active-low):
- clock  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- push_en  in  1  qualified core store to TX data MMIO (0xfffffff4)
- push_data  in  32  store data (m_data.wd)
- push_stall  out  1  push_en & full; core holds the store
- free_count  out  32  free FIFO entries, zero-extended; returned on reads of 0xfffffff8
- tx_start  out  1  one-cycle start pulse to UartTx
- sdata  out  8  byte to send; valid while tx_start=1 and held until next pulse
- tx_busy  in  1  UartTx busy
- idle  out  1  FIFO empty and FSM in IDLE

## Operation
- FIFO: head/tail pointers log2(DEPTH) bits, count log2(DEPTH)+1 bits. Push accepted when push_en & ~full. Pop occurs when FSM loads a word.
- Full is evaluated on the registered count. A push in a full cycle stalls even if a pop happens the same cycle. A same-cycle push and pop on a non-full FIFO leaves count unchanged.
- Wrap-around: pointers wrap modulo DEPTH. free_count = DEPTH - count.
- FSM states:
  - IDLE: if count>0, copy head word to shift register, pop, clear byte index, go to SEND.
  - SEND: tx_start=1, sdata=current byte; go to ACK.
  - ACK: wait for tx_busy=1, then go to DRAIN.
  - DRAIN: wait for tx_busy=0. If more bytes remain, advance byte index and go to SEND. Otherwise go to IDLE.
- Bytes are sent LSB first. Byte count per word is set by configuration.
- Reset mid-operation: FIFO contents are discarded, the FSM returns to IDLE, and tx_start drops immediately. A byte already inside UartTx is not aborted.

## Timing
- Reset values: tx_start=0, sdata=8'h00, push_stall=0, free_count=DEPTH, idle=1, state=IDLE, pointers and count 0.
- tx_start and sdata are registered. push_stall and free_count are combinational from registered state plus push_en.
- Latency: push sampled at edge c on an empty, idle queue gives count=1 during c+1 and tx_start=1 during c+2.
- tx_start is never high for two consecutive cycles.
- Minimum gap between pulses is 3 cycles (SEND, ACK, DRAIN) plus UartTx busy time.
- UartTx raises tx_busy within one cycle of tx_start. The ACK state tolerates arbitrary delay.

## Configuration
- UART_TX_WORD_MODE_EN defined: each word sends 4 bytes, [7:0], [15:8], [23:16], [31:24]. Byte index is 2 bits.
- Undefined: each word sends only push_data[7:0]. The upper 24 bits are not stored, so FIFO width is 8.

## Structure
- Package uart_pkg:
  - tx_state_t enum (IDLE, SEND, ACK, DRAIN)
  - MMIO constants: UART_RX_DATA=32'hfffffff1, UART_RX_COUNT=32'hfffffff2, UART_TX_DATA=32'hfffffff4, UART_TX_FREE=32'hfffffff8
- Sub-module sync_fifo, parameterized by WIDTH and DEPTH, with push/pop/full/empty/count ports. The serializer FSM lives in uart_tx_queue.

## Test plan
- Single push 32'h0000_0041, UartTx model busy 10 cycles: tx_start in cycle c+2 with sdata=8'h41, then idle=1. In word mode, 4 pulses in order 41,00,00,00.
- DEPTH=16, tx_busy held 1, 17 pushes: free_count steps 16→0 (one pop after the first push), and push_stall=1 on the push that hits full. After releasing tx_busy, all bytes emerge in push order.
- Pointer wrap: push and drain 40 words with values 0..39: output sequence 0..39 with no loss or duplication.
- Push on the same cycle the FSM pops with count=5: count stays 5 and free_count stays 11.
- Assert reset mid-DRAIN with 3 words queued: tx_start=0 immediately, free_count=16, idle=1. No further pulses after reset release.
- tx_busy delayed 4 cycles after tx_start: FSM waits in ACK, and no second tx_start occurs before tx_busy has risen and fallen.
